// File: rtl/rca_ioctl_upload.sv
// rtl/rca_ioctl_upload.sv - HPS ioctl upload responder: serves image read-back through the memory arbiter
//
// Ports:
//   clk, reset_n                      system clock (clk_sys), synchronous active-low reset
//   ioctl_upload, ioctl_index         upload-in-progress level and active ioctl index from hps_io
//   ioctl_rd, ioctl_addr              single-cycle read strobe and 25-bit byte address
//   ioctl_din, ioctl_wait             returned byte and hold-off flag toward hps_io
//   save_trig, ioctl_upload_req       save request level in, one-cycle upload request pulse out
//   mem_req, mem_addr, mem_gnt, mem_q request/grant read port to the memory arbiter
//   busy                              transaction in flight
module rca_ioctl_upload #(
    parameter int           AW    = 12,
    parameter int           SIZE  = 4096,
    parameter logic [7:0]   INDEX = 8'h01,
    parameter int           LAT   = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ioctl_upload,
    input  logic [7:0]      ioctl_index,
    input  logic            ioctl_rd,
    input  logic [24:0]     ioctl_addr,
    output logic [7:0]      ioctl_din,
    output logic            ioctl_wait,
    input  logic            save_trig,
    output logic            ioctl_upload_req,
    output logic            mem_req,
    output logic [AW-1:0]   mem_addr,
    input  logic            mem_gnt,
    input  logic [7:0]      mem_q,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    localparam logic [1:0]  LAT_C  = 2'(LAT);
    localparam logic [24:0] SIZE_C = 25'(SIZE);

    state_t         state, state_nxt;
    logic [1:0]     cnt, cnt_nxt;
    logic [7:0]     din_nxt;
    logic [AW-1:0]  addr_nxt;
    logic           save_d;
    logic           accept;
    logic           in_range;

    // A strobe is only considered on an IDLE cycle; anything else is dropped.
    assign accept   = (state == IDLE) & ioctl_rd & ioctl_upload & (ioctl_index == INDEX);
    // Full 25-bit compare so aliases above the image never touch memory.
    assign in_range = (ioctl_addr < SIZE_C);

    assign mem_req    = (state == REQ);
    assign busy       = (state != IDLE);
    // Asserted combinationally on the accepting cycle so HPS never samples stale data.
    assign ioctl_wait = busy | (accept & in_range);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        din_nxt   = ioctl_din;
        addr_nxt  = mem_addr;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_range) begin
                        state_nxt = REQ;
                        addr_nxt  = ioctl_addr[AW-1:0];
                    end else begin
                        din_nxt = 8'hFF;
                    end
                end
            end
            REQ: begin
                if (!ioctl_upload) begin
                    state_nxt = IDLE;
                end else if (mem_gnt) begin
                    state_nxt = WAIT;
                    cnt_nxt   = LAT_C;
                end
            end
            WAIT: begin
                // Abort takes priority: a late mem_q must not overwrite ioctl_din.
                if (!ioctl_upload) begin
                    state_nxt = IDLE;
                end else if (cnt <= 2'd1) begin
                    din_nxt   = mem_q;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= IDLE;
            cnt              <= 2'd0;
            ioctl_din        <= 8'h00;
            mem_addr         <= '0;
            // Treat save_trig as already high so a level present at release does not pulse.
            save_d           <= 1'b1;
            ioctl_upload_req <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            ioctl_din        <= din_nxt;
            mem_addr         <= addr_nxt;
            save_d           <= save_trig;
            ioctl_upload_req <= save_trig & ~save_d & ~ioctl_upload;
        end
    end

endmodule

// File: tb/tb_rca_ioctl_upload.sv
// tb/tb_rca_ioctl_upload.sv - cycle-table and directed checks for rca_ioctl_upload
module tb_rca_ioctl_upload;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic [7:0]  ioctl_index = 8'h00;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        save_trig = 1'b0;
    logic        ioctl_upload_req;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic [7:0]  mem_q = 8'h00;
    logic        busy;

    logic [7:0]  mem [0:4095];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rca_ioctl_upload dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ioctl_upload     (ioctl_upload),
        .ioctl_index      (ioctl_index),
        .ioctl_rd         (ioctl_rd),
        .ioctl_addr       (ioctl_addr),
        .ioctl_din        (ioctl_din),
        .ioctl_wait       (ioctl_wait),
        .save_trig        (save_trig),
        .ioctl_upload_req (ioctl_upload_req),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_gnt          (mem_gnt),
        .mem_q            (mem_q),
        .busy             (busy)
    );

    // Memory with one cycle of read latency after the grant cycle.
    always @(posedge clk) begin
        if (mem_req && mem_gnt)
            mem_q <= mem[mem_addr];
    end

    typedef struct {
        logic        chk;
        logic        rst_n;
        logic        upload;
        logic [7:0]  idx;
        logic        rd;
        logic [24:0] addr;
        logic        gnt;
        logic        save;
        logic [7:0]  e_din;
        logic        e_wait;
        logic        e_req;
        logic        e_busy;
        logic        e_upreq;
        logic [11:0] e_addr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic chk, input logic rst_n, input logic upload, input logic [7:0] idx,
                       input logic rd, input logic [24:0] addr, input logic gnt, input logic save,
                       input logic [7:0] e_din, input logic e_wait, input logic e_req,
                       input logic e_busy, input logic e_upreq, input logic [11:0] e_addr);
        vec_t v;
        v.chk = chk; v.rst_n = rst_n; v.upload = upload; v.idx = idx; v.rd = rd; v.addr = addr;
        v.gnt = gnt; v.save = save; v.e_din = e_din; v.e_wait = e_wait; v.e_req = e_req;
        v.e_busy = e_busy; v.e_upreq = e_upreq; v.e_addr = e_addr;
        tbl.push_back(v);
    endtask

    task automatic check_bit(input int row, input string name, input logic act, input logic exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL row %0d %s: got %b expected %b", row, name, act, exp);
        end
    endtask

    task automatic check_byte(input int row, input string name, input logic [11:0] act, input logic [11:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
        end
    endtask

    initial begin
        int waits;
        int reqs;
        int pulses;
        logic got_data;
        logic [7:0] exp_q;

        for (int i = 0; i < 4096; i++)
            mem[i] = 8'(i) ^ 8'h5A;
        mem[5] = 8'hA7;

        // chk rst up idx rd addr gnt save | din wait req busy upreq mem_addr
        add(0, 0, 0, 8'd0, 0, 25'h0,    0, 0,  8'h00, 0, 0, 0, 0, 12'h000);
        add(1, 1, 0, 8'd0, 0, 25'h0,    0, 0,  8'h00, 0, 0, 0, 0, 12'h000);
        // in-range read, grant already high
        add(1, 1, 1, 8'd1, 1, 25'h005,  1, 0,  8'h00, 1, 0, 0, 0, 12'h000);
        add(1, 1, 1, 8'd1, 0, 25'h0,    1, 0,  8'h00, 1, 1, 1, 0, 12'h005);
        add(1, 1, 1, 8'd1, 0, 25'h0,    1, 0,  8'h00, 1, 0, 1, 0, 12'h005);
        add(1, 1, 1, 8'd1, 0, 25'h0,    1, 0,  8'hA7, 0, 0, 0, 0, 12'h005);
        // out-of-range read at SIZE
        add(1, 1, 1, 8'd1, 1, 25'h1000, 1, 0,  8'hA7, 0, 0, 0, 0, 12'h005);
        add(1, 1, 1, 8'd1, 0, 25'h0,    1, 0,  8'hFF, 0, 0, 0, 0, 12'h005);
        add(1, 1, 1, 8'd1, 0, 25'h0,    1, 0,  8'hFF, 0, 0, 0, 0, 12'h005);
        // grant held off 4 cycles
        add(1, 1, 1, 8'd1, 1, 25'h005,  0, 0,  8'hFF, 1, 0, 0, 0, 12'h005);
        add(1, 1, 1, 8'd1, 0, 25'h0,    0, 0,  8'hFF, 1, 1, 1, 0, 12'h005);
        add(1, 1, 1, 8'd0, 1, 25'h007,  0, 0,  8'hFF, 1, 1, 1, 0, 12'h005);
        add(1, 1, 1, 8'd1, 0, 25'h0,    0, 0,  8'hFF, 1, 1, 1, 0, 12'h005);
        add(1, 1, 1, 8'd1, 0, 25'h0,    0, 0,  8'hFF, 1, 1, 1, 0, 12'h005);
        add(1, 1, 1, 8'd1, 0, 25'h0,    1, 0,  8'hFF, 1, 1, 1, 0, 12'h005);
        add(1, 1, 1, 8'd1, 0, 25'h0,    1, 0,  8'hFF, 1, 0, 1, 0, 12'h005);
        add(1, 1, 1, 8'd1, 0, 25'h0,    1, 0,  8'hA7, 0, 0, 0, 0, 12'h005);
        // wrong index, then no upload: ignored
        add(1, 1, 1, 8'd0, 1, 25'h007,  1, 0,  8'hA7, 0, 0, 0, 0, 12'h005);
        add(1, 1, 1, 8'd0, 0, 25'h0,    1, 0,  8'hA7, 0, 0, 0, 0, 12'h005);
        add(1, 1, 0, 8'd1, 1, 25'h007,  1, 0,  8'hA7, 0, 0, 0, 0, 12'h005);
        add(1, 1, 0, 8'd1, 0, 25'h0,    1, 0,  8'hA7, 0, 0, 0, 0, 12'h005);
        // strobe on final WAIT cycle ignored, then accepted on first IDLE cycle
        add(1, 1, 1, 8'd1, 1, 25'h0FF,  1, 0,  8'hA7, 1, 0, 0, 0, 12'h005);
        add(1, 1, 1, 8'd1, 0, 25'h0,    1, 0,  8'hA7, 1, 1, 1, 0, 12'h0FF);
        add(1, 1, 1, 8'd1, 1, 25'h010,  1, 0,  8'hA7, 1, 0, 1, 0, 12'h0FF);
        add(1, 1, 1, 8'd1, 1, 25'h010,  1, 0,  8'hA5, 1, 0, 0, 0, 12'h0FF);
        add(1, 1, 1, 8'd1, 0, 25'h0,    1, 0,  8'hA5, 1, 1, 1, 0, 12'h010);
        add(1, 1, 1, 8'd1, 0, 25'h0,    1, 0,  8'hA5, 1, 0, 1, 0, 12'h010);
        add(1, 1, 1, 8'd1, 0, 25'h0,    1, 0,  8'h4A, 0, 0, 0, 0, 12'h010);
        // upload dropped in REQ with grant low
        add(1, 1, 1, 8'd1, 1, 25'h005,  0, 0,  8'h4A, 1, 0, 0, 0, 12'h010);
        add(1, 1, 0, 8'd1, 0, 25'h0,    0, 0,  8'h4A, 1, 1, 1, 0, 12'h005);
        add(1, 1, 0, 8'd1, 0, 25'h0,    0, 0,  8'h4A, 0, 0, 0, 0, 12'h005);
        add(1, 1, 0, 8'd1, 0, 25'h0,    1, 0,  8'h4A, 0, 0, 0, 0, 12'h005);
        // reset during WAIT
        add(1, 1, 1, 8'd1, 1, 25'h005,  1, 0,  8'h4A, 1, 0, 0, 0, 12'h005);
        add(1, 1, 1, 8'd1, 0, 25'h0,    1, 0,  8'h4A, 1, 1, 1, 0, 12'h005);
        add(1, 0, 1, 8'd1, 0, 25'h0,    1, 0,  8'h4A, 1, 0, 1, 0, 12'h005);
        add(1, 1, 1, 8'd1, 0, 25'h0,    1, 0,  8'h00, 0, 0, 0, 0, 12'h000);
        // save held high with upload=0: one pulse
        add(1, 1, 0, 8'd1, 0, 25'h0,    0, 1,  8'h00, 0, 0, 0, 0, 12'h000);
        add(1, 1, 0, 8'd1, 0, 25'h0,    0, 1,  8'h00, 0, 0, 0, 1, 12'h000);
        for (int i = 0; i < 8; i++)
            add(1, 1, 0, 8'd1, 0, 25'h0, 0, 1, 8'h00, 0, 0, 0, 0, 12'h000);
        add(1, 1, 0, 8'd1, 0, 25'h0,    0, 0,  8'h00, 0, 0, 0, 0, 12'h000);
        // save edge while uploading: dropped
        for (int i = 0; i < 4; i++)
            add(1, 1, 1, 8'd1, 0, 25'h0, 0, 1, 8'h00, 0, 0, 0, 0, 12'h000);
        add(1, 1, 1, 8'd1, 0, 25'h0,    0, 0,  8'h00, 0, 0, 0, 0, 12'h000);
        // save already high across reset release: no pulse
        add(1, 0, 0, 8'd1, 0, 25'h0,    0, 1,  8'h00, 0, 0, 0, 0, 12'h000);
        add(1, 1, 0, 8'd1, 0, 25'h0,    0, 1,  8'h00, 0, 0, 0, 0, 12'h000);
        add(1, 1, 0, 8'd1, 0, 25'h0,    0, 1,  8'h00, 0, 0, 0, 0, 12'h000);
        add(1, 1, 0, 8'd1, 0, 25'h0,    0, 0,  8'h00, 0, 0, 0, 0, 12'h000);

        foreach (tbl[r]) begin
            @(posedge clk);
            #1;
            reset_n      = tbl[r].rst_n;
            ioctl_upload = tbl[r].upload;
            ioctl_index  = tbl[r].idx;
            ioctl_rd     = tbl[r].rd;
            ioctl_addr   = tbl[r].addr;
            mem_gnt      = tbl[r].gnt;
            save_trig    = tbl[r].save;
            @(negedge clk);
            if (tbl[r].chk) begin
                n_vec++;
                check_byte(r, "ioctl_din", {4'h0, ioctl_din}, {4'h0, tbl[r].e_din});
                check_bit (r, "ioctl_wait", ioctl_wait, tbl[r].e_wait);
                check_bit (r, "mem_req", mem_req, tbl[r].e_req);
                check_bit (r, "busy", busy, tbl[r].e_busy);
                check_bit (r, "ioctl_upload_req", ioctl_upload_req, tbl[r].e_upreq);
                check_byte(r, "mem_addr", mem_addr, tbl[r].e_addr);
            end
        end

        // Grant delay sweep: wait spans d+3 cycles, mem_req d+1 cycles, data lands when wait drops.
        for (int d = 0; d < 4; d++) begin
            waits = 0;
            reqs = 0;
            got_data = 1'b0;
            exp_q = 8'(12'h020 + 12'(d)) ^ 8'h5A;
            for (int k = 0; k < 16; k++) begin
                @(posedge clk);
                #1;
                reset_n      = 1'b1;
                ioctl_upload = 1'b1;
                ioctl_index  = 8'd1;
                ioctl_rd     = (k == 0);
                ioctl_addr   = 25'h020 + 25'(d);
                mem_gnt      = (k > d);
                save_trig    = 1'b0;
                @(negedge clk);
                if (ioctl_wait) waits++;
                if (mem_req) reqs++;
                if (!ioctl_wait && k > 0 && !got_data) begin
                    got_data = 1'b1;
                    n_vec++;
                    check_byte(100 + d, "sweep_din", {4'h0, ioctl_din}, {4'h0, exp_q});
                end
            end
            n_vec++;
            if (!got_data) begin
                n_err++;
                $display("FAIL sweep %0d timeout: ioctl_wait never dropped", d);
            end
            if (waits != d + 3) begin
                n_err++;
                $display("FAIL sweep %0d wait_cycles: got %0d expected %0d", d, waits, d + 3);
            end
            if (reqs != d + 1) begin
                n_err++;
                $display("FAIL sweep %0d req_cycles: got %0d expected %0d", d, reqs, d + 1);
            end
        end

        // Save held 10 cycles after a low period: exactly one pulse.
        pulses = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1;
            ioctl_upload = 1'b0;
            ioctl_rd     = 1'b0;
            save_trig    = (k >= 2 && k < 12);
            @(negedge clk);
            if (ioctl_upload_req) pulses++;
        end
        n_vec++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL save_pulse_count: got %0d expected 1", pulses);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
